// File: rtl/vppm_pkg.sv
// Shared VPPM framing constants and state encoding for the transmitter and the receiver.
// Keep these values identical on both sides of the optical link.
package vppm_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SYNC_LO  = 3'd2;
    localparam logic [2:0] ST_SYNC_HI  = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;

    typedef enum logic [2:0] {
        VPPM_IDLE     = ST_IDLE,
        VPPM_PREAMBLE = ST_PREAMBLE,
        VPPM_SYNC_LO  = ST_SYNC_LO,
        VPPM_SYNC_HI  = ST_SYNC_HI,
        VPPM_DATA     = ST_DATA
    } vppm_state_e;

    // The first preamble symbol is the MSB.
    localparam logic [9:0] PREAMBLE_PAT     = 10'b1010101010;
    localparam int         PREAMBLE_SYMBOLS = 10;
    localparam int         SYNC_SYMBOLS     = 2;

endpackage

// File: rtl/vppm_sym_timer.sv
// In-symbol clock counter with symbol-end flag and VPPM pulse compare.
// The level is evaluated on the next counter value, so the parent can register it in step with its state.
module vppm_sym_timer #(
    parameter int NBCNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             start,
    input  logic [NBCNT-1:0] p,
    input  logic [NBCNT-1:0] d,
    input  logic             bit_val,
    output logic             level,
    output logic             sym_end
);

    logic [NBCNT-1:0] cnt_q;
    logic [NBCNT-1:0] cnt_d;

    always_comb begin
        sym_end = run && (cnt_q == p - NBCNT'(1));
        cnt_d   = '0;
        if (start) begin
            cnt_d = '0;
        end else if (run && !sym_end) begin
            cnt_d = cnt_q + NBCNT'(1);
        end
        // A 1 pulses at the start of the symbol, a 0 at its end; d < p keeps p-d from underflowing.
        level = bit_val ? (cnt_d < d) : (cnt_d >= p - d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vppm_tx.sv
// VPPM frame transmitter: preamble, sync marker, then the payload MSB first, with a registered line output.
// The first symbol cycle appears the cycle after accept; msg_ready is high only when idle, including the done cycle.
module vppm_tx
    import vppm_pkg::*;
#(
    parameter int NBITS_MSG = 128,
    parameter int NBCNT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBCNT-1:0]     period,
    input  logic [NBCNT-1:0]     duty,
    input  logic [NBITS_MSG-1:0] msg_data,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    output logic                 vppm_out,
    output logic                 busy,
    output logic                 done
);

    localparam int IDXW = $clog2(NBITS_MSG) + 4;

    logic [2:0]           state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [NBITS_MSG-1:0] msg_q, msg_d;
    logic [NBCNT-1:0]     p_q, p_d, d_q, d_d;
    logic                 out_q, out_d;
    logic                 done_q, done_d;
    logic [NBCNT-1:0]     p_clamp, d_clamp;
    logic                 start, bit_d, level, sym_end;

    always_comb begin
        p_clamp = (period < NBCNT'(2)) ? NBCNT'(2) : period;
        if (duty == '0) begin
            d_clamp = NBCNT'(1);
        end else if (duty >= p_clamp) begin
            d_clamp = p_clamp - NBCNT'(1);
        end else begin
            d_clamp = duty;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        msg_d   = msg_q;
        p_d     = p_q;
        d_d     = d_q;
        done_d  = 1'b0;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (msg_valid) begin
                    state_d = ST_PREAMBLE;
                    idx_d   = '0;
                    msg_d   = msg_data;
                    p_d     = p_clamp;
                    d_d     = d_clamp;
                    start   = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (sym_end) begin
                    if (idx_q == IDXW'(PREAMBLE_SYMBOLS - 1)) begin
                        state_d = ST_SYNC_LO;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            ST_SYNC_LO: if (sym_end) state_d = ST_SYNC_HI;
            ST_SYNC_HI: if (sym_end) state_d = ST_DATA;
            ST_DATA: begin
                if (sym_end) begin
                    if (idx_q == IDXW'(NBITS_MSG - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                        msg_d = msg_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output is registered, so it is derived from the state about to be entered.
        bit_d = (state_d == ST_PREAMBLE) ? PREAMBLE_PAT[4'd9 - idx_d[3:0]] : msg_d[NBITS_MSG-1];
        case (state_d)
            ST_PREAMBLE, ST_DATA: out_d = level;
            ST_SYNC_HI:           out_d = 1'b1;
            default:              out_d = 1'b0;
        endcase
    end

    vppm_sym_timer #(.NBCNT(NBCNT)) u_sym_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q != ST_IDLE),
        .start   (start),
        .p       (p_d),
        .d       (d_d),
        .bit_val (bit_d),
        .level   (level),
        .sym_end (sym_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            msg_q   <= '0;
            p_q     <= NBCNT'(2);
            d_q     <= NBCNT'(1);
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
            p_q     <= p_d;
            d_q     <= d_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign msg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign vppm_out  = out_q;
    assign done      = done_q;

endmodule
